// File: rtl/barret_1409_rr_sched.sv
// barret_1409_rr_sched: round-robin arbiter feeding one shared Barrett mod-1409 reducer through a two-stage pipeline
module barret_1409_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DIN_W   = 21,
    parameter int DOUT_W  = 11,
    parameter int PRIME   = 1409
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*DIN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [DIN_W-1:0]         red_a,
    input  logic [DOUT_W-1:0]        red_r,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DOUT_W-1:0]        rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_err,
    output logic                     busy
);
    logic              s1_valid, s1_err, s2_adv, s1_load, gnt_any;
    logic [DIN_W-1:0]  s1_a, gnt_a;
    logic [ID_W-1:0]   s1_id, rr_ptr, gnt_id, idx;

    assign s2_adv  = s1_valid & (~rsp_valid | rsp_ready);
    assign s1_load = ~s1_valid | s2_adv;

    // Scan from the highest offset down so the requester nearest rr_ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = rr_ptr + ID_W'(k);
            if (req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    assign gnt_a     = req_data[gnt_id*DIN_W +: DIN_W];
    assign req_ready = (s1_load & gnt_any & ~rst) ? NUM_REQ'(1) << gnt_id : '0;
    assign red_a     = s1_a;
    assign busy      = s1_valid | rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_id     <= '0;
            s1_err    <= 1'b0;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= gnt_any;
                if (gnt_any) begin
                    s1_a   <= gnt_a;
                    s1_id  <= gnt_id;
                    s1_err <= gnt_a >= DIN_W'(PRIME * PRIME);
                    rr_ptr <= gnt_id + ID_W'(1);
                end
            end
            if (s2_adv) begin
                rsp_valid <= 1'b1;
                rsp_data  <= red_r;
                rsp_id    <= s1_id;
                rsp_err   <= s1_err;
            end else if (rsp_valid & rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_barret_1409_rr_sched.sv
// tb_barret_1409_rr_sched: directed bench with a behavioural mod-1409 reducer standing in for the shared instance
module tb_barret_1409_rr_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [83:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [20:0] red_a;
    logic [10:0] red_r;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [10:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_err;
    logic        busy;
    int          n_vec = 0;
    int          n_err = 0;
    int          exp3 [4] = '{1408, 1, 1408, 5};

    always #5 clk = ~clk;

    assign red_r = 11'(red_a % 21'd1409);

    barret_1409_rr_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .red_a(red_a), .red_r(red_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int v);
        req_data[i*21 +: 21] = 21'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // reset state, with every requester asserting valid
        req_valid = 4'b1111;
        tick();
        tick();
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_red_a", red_a, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_err", rsp_err, 0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        // single operand 1409 from requester 0
        rsp_ready = 1'b1;
        set_op(0, 1409);
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        #1;
        chk("t1_red_a", red_a, 1409);
        chk("t1_early", rsp_valid, 0);
        tick();
        #1;
        chk("t1_valid", rsp_valid, 1);
        chk("t1_data", rsp_data, 0);
        chk("t1_id", rsp_id, 0);
        chk("t1_err", rsp_err, 0);
        tick();
        #1;
        chk("t1_drain", rsp_valid, 0);
        chk("t1_busy", busy, 0);

        // back-to-back sweep from requester 2
        req_valid = 4'b0100;
        for (int i = 0; i <= 1408; i++) begin
            set_op(2, i);
            #1;
            chk("t2_ready", req_ready, 4'b0100);
            if (i >= 2) begin
                chk("t2_valid", rsp_valid, 1);
                chk("t2_data", rsp_data, i - 2);
                chk("t2_id", rsp_id, 2);
            end
            tick();
        end
        req_valid = '0;
        #1;
        chk("t2_tail0", rsp_data, 1407);
        tick();
        #1;
        chk("t2_tail1", rsp_data, 1408);
        chk("t2_tail1v", rsp_valid, 1);
        tick();
        #1;
        chk("t2_idle", rsp_valid, 0);

        // all requesters valid from reset: strict rotation
        set_op(0, 2817);
        set_op(1, 1982464);
        set_op(2, 1985280);
        set_op(3, 5);
        req_valid = 4'b1111;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t3_ready", req_ready, 4'b0001 << (k % 4));
            if (k >= 2) begin
                chk("t3_data", rsp_data, exp3[(k - 2) % 4]);
                chk("t3_id", rsp_id, (k - 2) % 4);
                chk("t3_err", rsp_err, 0);
            end
            tick();
        end

        // backpressure with both stages full
        for (int i = 0; i < 4; i++) set_op(i, 100 + i);
        rsp_ready = 1'b0;
        do_reset();
        #1;
        chk("t4_ready0", req_ready, 4'b0001);
        tick();
        #1;
        chk("t4_ready1", req_ready, 4'b0010);
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t4_stall_ready", req_ready, 0);
            chk("t4_stall_valid", rsp_valid, 1);
            chk("t4_stall_data", rsp_data, 100);
            chk("t4_stall_id", rsp_id, 0);
            chk("t4_stall_red_a", red_a, 101);
            tick();
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t4_ready", req_ready, 4'b0001 << ((k + 2) % 4));
            chk("t4_valid", rsp_valid, 1);
            chk("t4_data", rsp_data, 100 + k);
            chk("t4_id", rsp_id, k);
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        tick();
        #1;
        chk("t4_drained", busy, 0);

        // out-of-range operand then a legal one from requester 3
        set_op(3, 2000000);
        req_valid = 4'b1000;
        #1;
        chk("t5_ready0", req_ready, 4'b1000);
        tick();
        set_op(3, 1410);
        #1;
        chk("t5_ready1", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        #1;
        chk("t5_err1", rsp_err, 1);
        chk("t5_id1", rsp_id, 3);
        tick();
        #1;
        chk("t5_err0", rsp_err, 0);
        chk("t5_data", rsp_data, 1);
        chk("t5_id", rsp_id, 3);
        tick();

        // reset pulse with both stages occupied
        set_op(1, 50);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        tick();
        tick();
        #1;
        chk("t6_full_busy", busy, 1);
        chk("t6_full_valid", rsp_valid, 1);
        rst = 1'b1;
        set_op(0, 3000);
        req_valid = 4'b1011;
        rsp_ready = 1'b1;
        #1;
        chk("t6_rst_ready", req_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_valid", rsp_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        #1;
        chk("t6_no_stale", rsp_valid, 0);
        tick();
        #1;
        chk("t6_rsp_valid", rsp_valid, 1);
        chk("t6_rsp_id", rsp_id, 0);
        chk("t6_rsp_data", rsp_data, 182);
        tick();
        #1;
        chk("t6_end_valid", rsp_valid, 0);
        chk("t6_end_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
